// File: rtl/cntr_gen.sv
// cntr_gen: parametrised up/down counter with wrap, saturate and auto-reload modes.
// Optional prescaler is enabled by defining CNTR_PRESCALE_EN.
module cntr_gen #(
  parameter int unsigned   W       = 16,
  parameter logic [W-1:0]  RST_VAL = '0,
  parameter int unsigned   PRESC   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         ld,
  input  logic         inc,
  input  logic         dec,
  input  logic [1:0]   mode,
  output logic [W-1:0] dout,
  output logic         zero,
  output logic         tc,
  output logic         ovf
);

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_RELOAD = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam logic [W-1:0] MAX_VAL = '1;

  if (W < 2 || W > 32) begin : g_bad_width
    $error("cntr_gen: W must lie in 2..32");
  end
  if (PRESC < 2 || PRESC > 256) begin : g_bad_presc
    $error("cntr_gen: PRESC must lie in 2..256");
  end

  logic [W-1:0] dout_q, dout_d;
  logic [W-1:0] rld_q, rld_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;
  logic         step_req;
  logic         step_en;
  logic         at_max;
  logic         at_min;
  mode_e        mode_sel;

  // A step is requested only when exactly one direction is asserted and no load.
  assign step_req = ~ld & (inc ^ dec);
  assign at_max   = (dout_q == MAX_VAL);
  assign at_min   = (dout_q == '0);
  assign mode_sel = mode_e'(mode);

`ifdef CNTR_PRESCALE_EN
  localparam int unsigned     PW         = (PRESC > 2) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC - 1);

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q;
    step_en = 1'b0;
    if (ld) begin
      presc_d = '0;
    end else if (step_req) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        step_en = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign step_en = step_req;
`endif

  always_comb begin
    dout_d = dout_q;
    rld_d  = rld_q;
    tc_d   = 1'b0;
    ovf_d  = 1'b0;
    if (ld) begin
      dout_d = din;
      rld_d  = din;
    end else if (step_en) begin
      if (inc) begin
        if (!at_max) begin
          dout_d = dout_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
          case (mode_sel)
            MODE_SAT, MODE_RSVD: dout_d = MAX_VAL;
            default:             dout_d = '0;
          endcase
        end
      end else begin
        if (!at_min) begin
          dout_d = dout_q - 1'b1;
        end else begin
          tc_d = 1'b1;
          case (mode_sel)
            MODE_WRAP:   dout_d = MAX_VAL;
            MODE_RELOAD: dout_d = rld_q;
            default:     dout_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= RST_VAL;
      rld_q  <= RST_VAL;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      rld_q  <= rld_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout = dout_q;
  assign zero = at_min;
  assign tc   = tc_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cntr_gen.sv
// Self-checking bench for cntr_gen (W=8): behavioural model, per-cycle compare,
// directed literal checks and randomized stimulus.
module tb_cntr_gen;
  localparam int W = 8;
  localparam logic [W-1:0] RST_V = 8'h5A;
  localparam int PRESC = 4;
  localparam int MAXV = 255;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         ld;
  logic         inc;
  logic         dec;
  logic [1:0]   mode;
  logic [W-1:0] dout;
  logic         zero;
  logic         tc;
  logic         ovf;

  int n_chk = 0;
  int n_fail = 0;

  cntr_gen #(.W(W), .RST_VAL(RST_V), .PRESC(PRESC)) dut (
    .clk(clk), .rst(rst), .din(din), .ld(ld), .inc(inc), .dec(dec),
    .mode(mode), .dout(dout), .zero(zero), .tc(tc), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic over the counting rules.
  int m_cnt, m_rld, m_pc;
  bit m_tc, m_ovf, m_valid = 0;

  always @(posedge clk) begin
    bit go;
    if (rst) begin
      m_cnt = RST_V; m_rld = RST_V; m_tc = 0; m_ovf = 0; m_pc = 0; m_valid = 1;
    end else if (m_valid) begin
      m_tc = 0; m_ovf = 0;
      if (ld) begin
        m_cnt = din; m_rld = din; m_pc = 0;
      end else if (inc != dec) begin
        go = 1;
`ifdef CNTR_PRESCALE_EN
        if (m_pc == PRESC - 1) m_pc = 0;
        else begin m_pc = m_pc + 1; go = 0; end
`endif
        if (go && inc) begin
          if (m_cnt == MAXV) begin
            m_ovf = 1;
            m_cnt = (mode == 2'd1 || mode == 2'd3) ? MAXV : 0;
          end else m_cnt = m_cnt + 1;
        end else if (go) begin
          if (m_cnt == 0) begin
            m_tc = 1;
            m_cnt = (mode == 2'd0) ? MAXV : (mode == 2'd2) ? m_rld : 0;
          end else m_cnt = m_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Compare process: every cycle once the model is reset.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("dout", int'(dout), m_cnt);
      check("zero", int'(zero), int'(m_cnt == 0));
      check("tc", int'(tc), int'(m_tc));
      check("ovf", int'(ovf), int'(m_ovf));
    end
  end

  task automatic cyc(input bit r, input bit l, input bit i, input bit d,
                     input logic [1:0] m, input logic [W-1:0] v);
    rst = r; ld = l; inc = i; dec = d; mode = m; din = v;
    @(negedge clk);
    $display("cyc rst=%0b ld=%0b inc=%0b dec=%0b mode=%0d din=%02h -> dout=%02h zero=%0b tc=%0b ovf=%0b",
             r, l, i, d, m, v, dout, zero, tc, ovf);
  endtask

  initial begin
    logic [W-1:0] dsel [6];
    bit bias;
    rst = 1; ld = 0; inc = 0; dec = 0; mode = 0; din = 0;
    @(negedge clk);
    cyc(1, 1, 0, 0, 0, 8'hAA);
    check("rst_over_ld", int'(dout), 8'h5A);
    check("rst_model", m_cnt, 8'h5A);
    check("rst_tc_ovf", int'({tc, ovf}), 0);
`ifdef CNTR_PRESCALE_EN
    cyc(0, 1, 0, 0, 0, 8'h10);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 0, 1, 0, 8'h00);
      check("presc_dec", int'(dout), (i < 4) ? 8'h10 : (i < 8) ? 8'h0F : 8'h0E);
    end
    check("presc_model", m_cnt, 8'h0E);
    cyc(0, 0, 0, 1, 0, 8'h00);
    cyc(0, 0, 0, 1, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h20);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 0, 1, 0, 8'h00);
      check("presc_restart", int'(dout), (i < 4) ? 8'h20 : 8'h1F);
    end
`else
    cyc(0, 1, 0, 0, 0, 8'h05);
    check("ld05", int'(dout), 8'h05);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 1, 0, 8'h00);
      check("dec_seq", int'(dout), 5 - i);
      check("dec_seq_tc", int'(tc), 0);
    end
    check("dec_zero", int'(zero), 1);
    cyc(0, 0, 0, 1, 2'd0, 8'h00);
    check("wrap_under", int'({dout, tc}), {8'hFF, 1'b1});
    cyc(0, 0, 0, 0, 2'd0, 8'h00);
    check("tc_one_cycle", int'(tc), 0);
    cyc(0, 0, 1, 0, 2'd0, 8'h00);
    check("wrap_over", int'({dout, ovf}), {8'h00, 1'b1});
    check("wrap_model", m_cnt, 0);
    cyc(0, 1, 0, 0, 2'd1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 2'd1, 8'h00);
      check("sat_under", int'({dout, tc}), {8'h00, 1'b1});
    end
    cyc(0, 1, 0, 0, 2'd3, 8'hFF);
    cyc(0, 0, 1, 0, 2'd3, 8'h00);
    check("sat_over", int'({dout, ovf}), {8'hFF, 1'b1});
    cyc(0, 1, 0, 0, 2'd2, 8'h03);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1, 2'd2, 8'h00);
      check("reload_seq", int'(dout), (i % 4 == 3) ? 3 : 2 - (i % 4));
      check("reload_tc", int'(tc), int'(i % 4 == 3));
    end
    cyc(0, 1, 0, 1, 2'd0, 8'h77);
    check("ld_over_dec", int'(dout), 8'h77);
    cyc(0, 0, 1, 1, 2'd0, 8'h00);
    check("both_hold", int'({dout, tc, ovf}), {8'h77, 2'b00});
    cyc(0, 1, 0, 0, 2'd0, 8'h00);
    cyc(0, 0, 1, 1, 2'd0, 8'h00);
    check("both_hold_zero", int'({dout, tc, ovf}), {8'h00, 2'b00});
`endif
    dsel[0] = 8'h00; dsel[1] = 8'h01; dsel[2] = 8'hFE;
    dsel[3] = 8'hFF; dsel[4] = 8'h03; dsel[5] = 8'h00;
    bias = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [W-1:0] v;
      if (n % 16 == 0) bias = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 99);
      v = ($urandom_range(0, 1) == 1) ? dsel[$urandom_range(0, 4)] : W'($urandom);
      cyc(r < 2, (r >= 2 && r < 8), bias ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0),
          bias ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0),
          2'($urandom_range(0, 3)), v);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
